// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // Widest write-port count the bypass helper handles.
  localparam int MAX_WR = 2;
  localparam int IDX_W  = (MAX_WR > 1) ? $clog2(MAX_WR) : 1;

  // Index of the highest-numbered (youngest) write port that matches.
  // Returns 0 when nothing matches; callers qualify with |hit.
  function automatic logic [IDX_W-1:0] hi_match(input logic [MAX_WR-1:0] hit);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: zero/enable gating, same-cycle write bypass, busy flag.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NWRITE = 2
) (
  input  logic                     rst_n,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NWRITE-1:0]        wclr,
  input  logic [2**ADDR_W-1:0]     busy,
  input  logic [DATA_W-1:0]        regs [2**ADDR_W],
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  logic [MAX_WR-1:0] hit;
  logic [DATA_W-1:0] wd [MAX_WR];
  logic [MAX_WR-1:0] wc;
  logic [IDX_W-1:0]  sel;

  // Select bypassed write data (youngest port first) or stored value.
  always_comb begin
    hit   = '0;
    wc    = '0;
    for (int i = 0; i < MAX_WR; i++) wd[i] = '0;
    for (int i = 0; i < NWRITE; i++) begin
      hit[i] = we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr);
      wd[i]  = wdata[i*DATA_W +: DATA_W];
      wc[i]  = wclr[i];
    end
    sel   = hi_match(hit);
    rdata = '0;
    rbusy = 1'b0;
    if (rst_n && re && (raddr != ADDR_W'(REG_ZERO))) begin
      if (|hit) begin
        rdata = wd[sel];
        // A clearing write being forwarded makes the value valid now.
        rbusy = busy[raddr] & ~wc[sel];
      end else begin
        rdata = regs[raddr];
        rbusy = busy[raddr];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with write bypass and per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NWRITE-1:0]        wclr,
  input  logic [NREAD-1:0]         re,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              set_eff;
  logic              inc;
  logic [CNT_W-1:0]  dec;
  logic [ADDR_W-1:0] wa;
  logic              clr_i;
  logic              dup;

  // Storage; later (younger) ports overwrite earlier ones on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)))
          regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next busy vector and the effective set/clear transitions for the count.
  always_comb begin
    busy_nxt = busy;
    dec      = '0;
    wa       = '0;
    clr_i    = 1'b0;
    dup      = 1'b0;
    set_eff  = sb_set && (sb_addr != ADDR_W'(REG_ZERO));
    for (int i = 0; i < NWRITE; i++) begin
      wa    = waddr[i*ADDR_W +: ADDR_W];
      clr_i = we[i] && wclr[i] && (wa != ADDR_W'(REG_ZERO));
      dup   = 1'b0;
      for (int k = 0; k < i; k++) begin
        if (we[k] && wclr[k] && (waddr[k*ADDR_W +: ADDR_W] == wa)) dup = 1'b1;
      end
      // Count a clear once per address, and not when a new producer re-sets it.
      if (clr_i && !dup && busy[wa] && !(set_eff && (sb_addr == wa)))
        dec = dec + CNT_W'(1);
      if (clr_i) busy_nxt[wa] = 1'b0;
    end
    if (set_eff) busy_nxt[sb_addr] = 1'b1;
    inc = set_eff && !busy[sb_addr];
  end

  // Scoreboard bits and their incrementally maintained population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + CNT_W'(inc) - dec;
    end
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWRITE (NWRITE)
    ) u_rdport (
      .rst_n (rst_n),
      .re    (re[j]),
      .raddr (raddr[j*ADDR_W +: ADDR_W]),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .wclr  (wclr),
      .busy  (busy),
      .regs  (regs),
      .rdata (rdata[j*DATA_W +: DATA_W]),
      .rbusy (rbusy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations queued as stimulus is driven.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NW-1:0]    wclr;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic [AW:0]      busy_cnt;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .wclr(wclr), .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return rdata[31:0];
      1:       return rdata[63:32];
      2:       return {31'b0, rbusy[0]};
      3:       return {31'b0, rbusy[1]};
      default: return {26'b0, busy_cnt};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mregs[k] = '0;
    mbusy = '0;
    mcnt  = 0;
  endtask

  // Expected combinational outputs from the current inputs and model state.
  task automatic predict();
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          b;
    logic          hitf;
    for (int j = 0; j < NR; j++) begin
      a = raddr[j*AW +: AW];
      d = '0;
      b = 1'b0;
      if (rst_n && re[j] && a != 0) begin
        hitf = 1'b0;
        for (int i = 0; i < NW; i++) begin
          if (we[i] && waddr[i*AW +: AW] == a) begin
            hitf = 1'b1;
            d    = wdata[i*DW +: DW];
            b    = mbusy[a] && !wclr[i];
          end
        end
        if (!hitf) begin
          d = mregs[a];
          b = mbusy[a];
        end
      end
      push($sformatf("rdata%0d", j), j, d);
      push($sformatf("rbusy%0d", j), 2 + j, {31'b0, b});
    end
    push("busy_cnt", 4, mcnt);
  endtask

  task automatic model_edge();
    logic [31:0] nb;
    if (rst_n) begin
      for (int i = 0; i < NW; i++)
        if (we[i] && waddr[i*AW +: AW] != 0) mregs[waddr[i*AW +: AW]] = wdata[i*DW +: DW];
      nb = mbusy;
      for (int i = 0; i < NW; i++)
        if (we[i] && wclr[i] && waddr[i*AW +: AW] != 0) nb[waddr[i*AW +: AW]] = 1'b0;
      if (sb_set && sb_addr != 0) nb[sb_addr] = 1'b1;
      mbusy = nb;
      mcnt  = $countones(nb);
    end
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cyc();
    #2;
    predict();
    drain();
    @(posedge clk);
    #1;
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr_in();
    we = '0; waddr = '0; wdata = '0; wclr = '0;
    re = '0; raddr = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic c);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    wclr[p] = c;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    re[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    model_reset();
    rd(0, 5'd5);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_cnt", {26'b0, busy_cnt}, 32'd0);
    chk("rst_rdata0", rdata[31:0], 32'd0);
    rst_n = 1'b1;
    clr_in();
    cyc();

    // Basic write then read on the other port
    wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
    cyc();
    clr_in(); rd(1, 5'd5);
    push("r5_read", 1, 32'hDEADBEEF);
    cyc();

    // Asynchronous reset mid-cycle, with a write and a set in flight
    clr_in(); rd(1, 5'd5); wr(0, 5'd6, 32'h5555AAAA, 1'b0);
    sb_set = 1'b1; sb_addr = 5'd6;
    #2;
    push("r5_before_rst", 1, 32'hDEADBEEF);
    drain();
    rst_n = 1'b0;
    #1;
    push("rdata_in_rst", 1, 32'd0);
    drain();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr_in(); rd(0, 5'd6); rd(1, 5'd5);
    push("r5_after_rst", 1, 32'd0);
    push("r6_discarded", 0, 32'd0);
    cyc();

    // r0 is never written, never bypassed, never busy
    clr_in(); wr(0, 5'd0, 32'h1234, 1'b1); wr(1, 5'd0, 32'h1234, 1'b1);
    rd(0, 5'd0); rd(1, 5'd0); sb_set = 1'b1; sb_addr = 5'd0;
    push("r0_nobypass", 0, 32'd0);
    cyc();
    clr_in(); rd(0, 5'd0);
    push("r0_cnt", 4, 32'd0);
    cyc();

    // Same-address conflict: port 1 wins
    clr_in(); wr(0, 5'd7, 32'h11, 1'b0); wr(1, 5'd7, 32'h22, 1'b0); rd(0, 5'd7);
    push("r7_bypass", 0, 32'h22);
    cyc();
    clr_in(); rd(1, 5'd7);
    push("r7_stored", 1, 32'h22);
    cyc();

    // Bypass, and re=0 gating
    clr_in(); wr(1, 5'd9, 32'hCAFE, 1'b0); rd(0, 5'd9); raddr[AW +: AW] = 5'd9;
    push("r9_bypass", 0, 32'hCAFE);
    push("r9_re0", 1, 32'd0);
    cyc();

    // Scoreboard set, clear by bypassed write, set-beats-clear
    clr_in(); sb_set = 1'b1; sb_addr = 5'd3;
    cyc();
    clr_in(); rd(0, 5'd3);
    push("r3_busy", 2, 32'd1);
    push("cnt_after_set", 4, 32'd1);
    cyc();
    clr_in(); wr(0, 5'd3, 32'h33, 1'b1); rd(0, 5'd3);
    push("r3_clr_bypass", 2, 32'd0);
    cyc();
    clr_in(); rd(0, 5'd3);
    push("cnt_after_clr", 4, 32'd0);
    sb_set = 1'b1; sb_addr = 5'd3;
    cyc();
    clr_in(); wr(0, 5'd3, 32'h34, 1'b1); sb_set = 1'b1; sb_addr = 5'd3;
    cyc();
    clr_in(); rd(1, 5'd3);
    push("r3_set_wins", 3, 32'd1);
    push("cnt_set_wins", 4, 32'd1);
    cyc();

    // Fill the scoreboard, then clear two at once
    for (int a = 1; a < 32; a++) begin
      clr_in(); sb_set = 1'b1; sb_addr = AW'(a); rd(0, AW'(a));
      cyc();
    end
    clr_in();
    push("cnt31", 4, 32'd31);
    cyc();
    clr_in(); wr(0, 5'd10, 32'hA, 1'b1); wr(1, 5'd20, 32'hB, 1'b1);
    cyc();
    clr_in();
    push("cnt29", 4, 32'd29);
    cyc();
    clr_in(); wr(0, 5'd11, 32'hC, 1'b1); wr(1, 5'd11, 32'hD, 1'b1);
    cyc();
    clr_in(); wr(0, 5'd10, 32'hE, 1'b1);
    push("cnt_dup_clr", 4, 32'd28);
    cyc();

    // Random traffic on a narrow address range to provoke collisions
    for (int n = 0; n < 80; n++) begin
      clr_in();
      for (int i = 0; i < NW; i++) begin
        we[i] = 1'($urandom_range(0, 1));
        waddr[i*AW +: AW] = AW'($urandom_range(0, 7));
        wdata[i*DW +: DW] = $urandom;
        wclr[i] = 1'($urandom_range(0, 1));
      end
      for (int j = 0; j < NR; j++) begin
        re[j] = 1'($urandom_range(0, 3) != 0);
        raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
      end
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = AW'($urandom_range(0, 7));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS core: the successor to the current 2-read/1-write register file. It provides NREAD read ports and NWRITE write ports, same-cycle write-to-read bypass, and a per-register busy scoreboard so decode can stall on outstanding producers such as loads and multi-cycle ops. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W; register 0 hardwired to zero
- NREAD, 2, number of read ports (1..4)
- NWRITE, 2, number of write ports (1..2); higher index = younger instruction
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  NWRITE  per-port write enable
- waddr  in  NWRITE*ADDR_W  write addresses, port i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NWRITE*DATA_W  write data
- wclr  in  NWRITE  per-port "clear busy on this write"
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*ADDR_W  read addresses
- rdata  out  NREAD*DATA_W  read data, combinational
- rbusy  out  NREAD  read register has an outstanding producer, combinational
- sb_set  in  1  mark sb_addr busy (issue of a long-latency producer)
- sb_addr  in  ADDR_W  register to mark
- busy_cnt  out  ADDR_W+1  number of busy registers, registered

## Operation
- Storage: 2**ADDR_W x DATA_W flops; entry 0 is never written and always reads 0.
- Write: on a rising edge with we[i]=1 and waddr[i]!=0, regs[waddr[i]] <= wdata[i]. If two ports hit the same address, the higher-index port wins.
- Read port j, in priority order:
  - rst_n=0, re[j]=0, or raddr[j]=0 -> rdata=0, rbusy=0.
  - Else if any we[i] && waddr[i]==raddr[j] -> bypass wdata of the highest matching i.
  - Else -> regs[raddr[j]].
- rbusy[j] = busy[raddr[j]], except that it is 0 when a same-cycle matching write with wclr set is being bypassed (the data is valid now).
- Scoreboard, one busy bit per register:
  - A write with wclr[i] clears the bit at waddr[i].
  - sb_set sets the bit at sb_addr.
  - When set and clear hit the same address in one cycle, set wins (the new producer is younger).
  - sb_addr=0 is ignored.
  - A clear of a non-busy register is harmless.
  - A write with wclr=0 leaves the bit unchanged.
- busy_cnt: population count of the busy bits, updated with them. It is maintained incrementally: +1 per effective 0->1 transition, -1 per effective 1->0 transition. It never exceeds 2**ADDR_W-1.

## Timing
- Reset (rst_n low, asynchronous): all regs=0, all busy=0, busy_cnt=0. rdata and rbusy are forced to 0 while rst_n is low.
- Read latency 0: rdata and rbusy depend combinationally on raddr, re, and the write ports.
- Write latency 1: data written at edge N is visible from regs after edge N, and is bypassed during cycle N.
- Scoreboard latency 1: a register set at edge N shows rbusy=1 from cycle N+1.
- Reset asserted mid-operation: in-flight writes and sets are discarded. No state survives, regardless of the clock.
- All flops are clocked on clk only; there are no other clocks or enables.

## Structure
- Shared package regfile_pkg:
  - Defaults for DATA_W and ADDR_W.
  - The constant REG_ZERO = 0.
  - A helper function for the highest-index match over write ports.
- Sub-module regfile_rdport: one read port's mux, bypass priority, and rbusy logic. It is instantiated NREAD times via generate.
- The top level holds the storage array, the write logic, the busy vector, and the busy_cnt counter.

## Test plan
- Reset and basic write: write 0xDEADBEEF to r5 via port 0, then read r5 on port 1 next cycle -> 0xDEADBEEF. Then assert rst_n low mid-cycle -> rdata=0 immediately; after release r5 reads 0.
- r0: write 0x1234 to r0 on both ports -> r0 reads 0, is not bypassed, and busy_cnt stays 0.
- Port conflict: port 0 writes 0x11 and port 1 writes 0x22 to r7 in the same cycle -> bypassed rdata=0x22, and stored value 0x22 next cycle.
- Bypass: read r9 while port 1 writes 0xCAFE to r9 -> rdata=0xCAFE in the same cycle. With re=0 -> rdata=0.
- Scoreboard:
  - sb_set r3 -> rbusy for r3 is 1 next cycle and busy_cnt=1.
  - Port 0 write to r3 with wclr=1 -> rbusy=0 during the write cycle (bypassed) and busy_cnt=0 after.
  - Simultaneous sb_set r3 and wclr write r3 -> r3 stays busy and busy_cnt is unchanged.
- Saturation: set r1..r31 on 31 consecutive cycles -> busy_cnt=31. Clearing two of them in one cycle via both write ports -> busy_cnt=29.
